// File: rtl/enemy_fire_scheduler.sv
// -----------------------------------------------------------------------------
// enemy_fire_scheduler
//
// Picks which enemy in the formation fires next and hands the request to the
// enemy munition. After each completed shot (or an empty search) it waits
// COOLDOWN_TICKS formation-movement ticks. It then walks the formation one
// column per cycle, starting at a round-robin pointer. The shooter is the
// bottom-most (highest row index) live enemy of the first column that has one.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset (overrides every other input)
//   enable      game running; low sends the scheduler to IDLE
//   tick        one-cycle formation-movement strobe, paces the cooldown
//   alive       ROWS*COLS alive bitmap, bit r*COLS+c = row r, column c
//   shot_busy   enemy munition currently in flight
//   fire_valid  fire request towards the munition (high only in REQUEST)
//   fire_ready  munition accepts the request this cycle
//   fire_row    row of the selected shooter
//   fire_col    column of the selected shooter
//   no_target   the last completed search found nobody alive
//   shot_count  number of accepted shots, wraps 255 -> 0
//
// Build option
//   ENEMY_FIRE_LFSR_EN  when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11,
//                       seed 16'hACE1) picks the start column of each search
//                       that follows a cooldown, instead of strict round-robin.
// -----------------------------------------------------------------------------
module enemy_fire_scheduler #(
    parameter int  ROWS           = 5,
    parameter int  COLS           = 11,
    parameter int  COOLDOWN_TICKS = 4,
    localparam int ROW_W          = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int COL_W          = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 tick,
    input  logic [ROWS*COLS-1:0] alive,
    input  logic                 shot_busy,
    output logic                 fire_valid,
    input  logic                 fire_ready,
    output logic [ROW_W-1:0]     fire_row,
    output logic [COL_W-1:0]     fire_col,
    output logic                 no_target,
    output logic [7:0]           shot_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COOLDOWN  = 3'd1,
        S_SEARCH    = 3'd2,
        S_REQUEST   = 3'd3,
        S_IN_FLIGHT = 3'd4
    } state_t;

    localparam logic [7:0] CD_LOAD        = 8'(COOLDOWN_TICKS);
    // A shot whose munition never reports busy is treated as finished on the
    // third IN_FLIGHT cycle, so COOLDOWN starts four cycles after the handshake.
    localparam logic [2:0] FLIGHT_TIMEOUT = 3'd3;

    // Round-robin successor of a column index.
    function automatic logic [COL_W-1:0] next_col(input logic [COL_W-1:0] c);
        if (c == COL_W'(COLS - 1)) begin
            next_col = {COL_W{1'b0}};
        end else begin
            next_col = c + COL_W'(1);
        end
    endfunction

    state_t           state_q, state_d;
    logic [7:0]       cd_cnt_q, cd_cnt_d;
    logic [COL_W-1:0] scan_col_q, scan_col_d;
    logic [COL_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [COL_W-1:0] ptr_q, ptr_d;
    logic [2:0]       flight_cnt_q, flight_cnt_d;
    logic             busy_seen_q, busy_seen_d;
    logic             fire_valid_q, fire_valid_d;
    logic [ROW_W-1:0] fire_row_q, fire_row_d;
    logic [COL_W-1:0] fire_col_q, fire_col_d;
    logic             no_target_q, no_target_d;
    logic [7:0]       shot_count_q, shot_count_d;

    logic             hit_s;
    logic [ROW_W-1:0] hit_row_s;
    logic             shooter_alive_s;
    logic             handshake_s;
    logic             shooter_lost_s;
    logic             miss_last_s;
    logic             flight_done_s;
    logic [COL_W-1:0] start_col_s;

`ifdef ENEMY_FIRE_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;

    // LFSR advance: Fibonacci, taps 16,14,13,11, steps every clock.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // LFSR register, reseeded on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // A search that follows a cooldown starts at a pseudo-random column; a
    // search restarted from REQUEST keeps the current pointer.
    always_comb begin
        if (state_q == S_COOLDOWN) begin
            start_col_s = COL_W'(lfsr_q % 16'(COLS));
        end else begin
            start_col_s = ptr_q;
        end
    end
`else
    // Strict round-robin: every search starts at the pointer.
    always_comb begin
        start_col_s = ptr_q;
    end
`endif

    // Column scan: bottom-most live enemy in the column under examination.
    always_comb begin
        hit_s     = 1'b0;
        hit_row_s = {ROW_W{1'b0}};
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if ((COL_W'(c) == scan_col_q) && alive[r*COLS + c]) begin
                    hit_s     = 1'b1;
                    hit_row_s = ROW_W'(r);
                end else begin
                    hit_s     = hit_s;
                    hit_row_s = hit_row_s;
                end
            end
        end
    end

    // Is the currently latched shooter still alive?
    always_comb begin
        shooter_alive_s = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if ((ROW_W'(r) == fire_row_q) && (COL_W'(c) == fire_col_q)) begin
                    shooter_alive_s = alive[r*COLS + c];
                end else begin
                    shooter_alive_s = shooter_alive_s;
                end
            end
        end
    end

    // Transition qualifiers used by the next-state logic.
    always_comb begin
        handshake_s    = fire_valid_q & fire_ready;
        shooter_lost_s = ~shooter_alive_s & ~fire_ready;
        miss_last_s    = ~hit_s & (miss_cnt_q == COL_W'(COLS - 1));
        flight_done_s  = ~shot_busy & (busy_seen_q | (flight_cnt_q == FLIGHT_TIMEOUT));
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cd_cnt_q     <= 8'd0;
            scan_col_q   <= {COL_W{1'b0}};
            miss_cnt_q   <= {COL_W{1'b0}};
            ptr_q        <= {COL_W{1'b0}};
            flight_cnt_q <= 3'd0;
            busy_seen_q  <= 1'b0;
            fire_valid_q <= 1'b0;
            fire_row_q   <= {ROW_W{1'b0}};
            fire_col_q   <= {COL_W{1'b0}};
            no_target_q  <= 1'b0;
            shot_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            cd_cnt_q     <= cd_cnt_d;
            scan_col_q   <= scan_col_d;
            miss_cnt_q   <= miss_cnt_d;
            ptr_q        <= ptr_d;
            flight_cnt_q <= flight_cnt_d;
            busy_seen_q  <= busy_seen_d;
            fire_valid_q <= fire_valid_d;
            fire_row_q   <= fire_row_d;
            fire_col_q   <= fire_col_d;
            no_target_q  <= no_target_d;
            shot_count_q <= shot_count_d;
        end
    end

    // Next-state logic; dropping enable returns to IDLE from anywhere.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_COOLDOWN;
                end
                S_COOLDOWN: begin
                    if (cd_cnt_q == 8'd0) begin
                        state_d = S_SEARCH;
                    end else begin
                        state_d = S_COOLDOWN;
                    end
                end
                S_SEARCH: begin
                    if (hit_s) begin
                        state_d = S_REQUEST;
                    end else if (miss_last_s) begin
                        state_d = S_COOLDOWN;
                    end else begin
                        state_d = S_SEARCH;
                    end
                end
                S_REQUEST: begin
                    if (handshake_s) begin
                        state_d = S_IN_FLIGHT;
                    end else if (shooter_lost_s) begin
                        state_d = S_SEARCH;
                    end else begin
                        state_d = S_REQUEST;
                    end
                end
                S_IN_FLIGHT: begin
                    if (flight_done_s) begin
                        state_d = S_COOLDOWN;
                    end else begin
                        state_d = S_IN_FLIGHT;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output and datapath updates, keyed on the transition being taken.
    always_comb begin
        cd_cnt_d     = cd_cnt_q;
        scan_col_d   = scan_col_q;
        miss_cnt_d   = miss_cnt_q;
        ptr_d        = ptr_q;
        flight_cnt_d = flight_cnt_q;
        busy_seen_d  = busy_seen_q;
        fire_row_d   = fire_row_q;
        fire_col_d   = fire_col_q;
        no_target_d  = no_target_q;
        shot_count_d = shot_count_q;
        fire_valid_d = (state_d == S_REQUEST);

        // Reload on entry takes precedence over a tick in the same cycle.
        if ((state_d == S_COOLDOWN) && (state_q != S_COOLDOWN)) begin
            cd_cnt_d = CD_LOAD;
        end else if ((state_q == S_COOLDOWN) && (state_d == S_COOLDOWN) && tick
                     && (cd_cnt_q != 8'd0)) begin
            cd_cnt_d = cd_cnt_q - 8'd1;
        end else begin
            cd_cnt_d = cd_cnt_q;
        end

        // Column walker. Writing start_col_s into ptr is a no-op in
        // round-robin mode and adopts the random start in LFSR mode.
        if ((state_d == S_SEARCH) && (state_q != S_SEARCH)) begin
            scan_col_d = start_col_s;
            miss_cnt_d = {COL_W{1'b0}};
            ptr_d      = start_col_s;
        end else if ((state_q == S_SEARCH) && (state_d == S_SEARCH)) begin
            scan_col_d = next_col(scan_col_q);
            miss_cnt_d = miss_cnt_q + COL_W'(1);
        end else begin
            scan_col_d = scan_col_q;
            miss_cnt_d = miss_cnt_q;
        end

        // Search outcome.
        if ((state_q == S_SEARCH) && (state_d == S_REQUEST)) begin
            fire_row_d  = hit_row_s;
            fire_col_d  = scan_col_q;
            no_target_d = 1'b0;
        end else if ((state_q == S_SEARCH) && (state_d == S_COOLDOWN)) begin
            no_target_d = 1'b1;
        end else begin
            no_target_d = no_target_q;
        end

        // Accepted shot, then in-flight tracking.
        if ((state_q == S_REQUEST) && (state_d == S_IN_FLIGHT)) begin
            shot_count_d = shot_count_q + 8'd1;
            ptr_d        = next_col(fire_col_q);
            flight_cnt_d = 3'd1;
            busy_seen_d  = 1'b0;
        end else if (state_q == S_IN_FLIGHT) begin
            busy_seen_d = busy_seen_q | shot_busy;
            if (flight_cnt_q != 3'd7) begin
                flight_cnt_d = flight_cnt_q + 3'd1;
            end else begin
                flight_cnt_d = flight_cnt_q;
            end
        end else begin
            flight_cnt_d = flight_cnt_q;
            busy_seen_d  = busy_seen_q;
        end
    end

    assign fire_valid = fire_valid_q;
    assign fire_row   = fire_row_q;
    assign fire_col   = fire_col_q;
    assign no_target  = no_target_q;
    assign shot_count = shot_count_q;

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Bench for enemy_fire_scheduler (ROWS=2, COLS=3, COOLDOWN_TICKS=2).
// A scheduling model runs alongside the DUT and is compared on every falling
// edge. Directed scenarios add hand-computed literal expectations.
module tb_enemy_fire_scheduler;

    localparam int ROWS = 2;
    localparam int COLS = 3;
    localparam int CDT  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       tick;
    logic [5:0] alive;
    logic       shot_busy;
    logic       fire_valid;
    logic       fire_ready;
    logic [0:0] fire_row;
    logic [1:0] fire_col;
    logic       no_target;
    logic [7:0] shot_count;

    int errors = 0;
    int checks = 0;

    enemy_fire_scheduler #(
        .ROWS(ROWS), .COLS(COLS), .COOLDOWN_TICKS(CDT)
    ) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .tick(tick), .alive(alive),
        .shot_busy(shot_busy), .fire_valid(fire_valid), .fire_ready(fire_ready),
        .fire_row(fire_row), .fire_col(fire_col), .no_target(no_target),
        .shot_count(shot_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scheduling model ----------------
    // phase: 0 idle, 1 cooldown, 2 searching, 3 requesting, 4 shot in flight
    int m_phase, m_wait, m_left, m_tr, m_tc, m_hit, m_ptr, m_age, m_seen;
    int m_row, m_col, m_valid, m_notgt, m_count;
    int m_live = 0;

    function automatic int alive_at(input int r, input int c);
        logic [5:0] v;
        v = alive;
        return int'(v[r*COLS + c]);
    endfunction

    // Decide up front how many search cycles are needed and what they find.
    task automatic plan_search();
        m_hit = 0;
        for (int o = 0; o < COLS; o++) begin
            if (m_hit == 0) begin
                for (int r = 0; r < ROWS; r++) begin
                    if (alive_at(r, (m_ptr + o) % COLS) == 1) begin
                        m_hit = 1;
                        m_tr  = r;
                        m_tc  = (m_ptr + o) % COLS;
                        m_left = o;
                    end
                end
            end
        end
        if (m_hit == 0) m_left = COLS - 1;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_wait = 0; m_ptr = 0; m_row = 0; m_col = 0;
            m_valid = 0; m_notgt = 0; m_count = 0; m_live = 1;
        end else if (!enable) begin
            m_phase = 0; m_valid = 0;
        end else begin
            case (m_phase)
                0: begin m_phase = 1; m_wait = CDT; end
                1: begin
                    if (m_wait == 0) begin m_phase = 2; plan_search(); end
                    else if (tick) m_wait--;
                end
                2: begin
                    if (m_left > 0) m_left--;
                    else if (m_hit == 1) begin
                        m_row = m_tr; m_col = m_tc; m_notgt = 0; m_valid = 1; m_phase = 3;
                    end else begin
                        m_notgt = 1; m_phase = 1; m_wait = CDT;
                    end
                end
                3: begin
                    if (fire_ready) begin
                        m_count = (m_count + 1) % 256; m_ptr = (m_col + 1) % COLS;
                        m_valid = 0; m_phase = 4; m_age = 0; m_seen = 0;
                    end else if (alive_at(m_row, m_col) == 0) begin
                        m_valid = 0; m_phase = 2; plan_search();
                    end
                end
                4: begin
                    m_age++;
                    if (!shot_busy && (m_seen == 1 || m_age >= 3)) begin
                        m_phase = 1; m_wait = CDT;
                    end
                    if (shot_busy) m_seen = 1;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Compare DUT against the model away from the active edge.
    always @(negedge clk) begin
        if (m_live == 1) begin
            chk("model fire_valid", int'(fire_valid), m_valid);
            chk("model fire_row",   int'(fire_row),   m_row);
            chk("model fire_col",   int'(fire_col),   m_col);
            chk("model no_target",  int'(no_target),  m_notgt);
            chk("model shot_count", int'(shot_count), m_count);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic give_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); tick = 1'b1;
            @(negedge clk); tick = 1'b0;
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (fire_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(fire_valid === 1'b1), 1);
    endtask

    // Cooldown, request, handshake, then a one-cycle shot_busy pulse.
    task automatic shot_cycle(input int r, input int c, input int cnt);
        give_ticks(CDT);
        wait_valid("request raised", 20);
        chk("shot row", int'(fire_row), r);
        chk("shot col", int'(fire_col), c);
        @(negedge clk);
        chk("count after handshake", int'(shot_count), cnt);
        chk("valid drops after handshake", int'(fire_valid), 0);
        shot_busy = 1'b1;
        @(negedge clk);
        shot_busy = 1'b0;
    endtask

    initial begin
        int saw_valid;
        reset = 1'b1; enable = 1'b0; tick = 1'b0; alive = 6'b000000;
        shot_busy = 1'b0; fire_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset fire_valid", int'(fire_valid), 0);
        chk("reset fire_row",   int'(fire_row),   0);
        chk("reset fire_col",   int'(fire_col),   0);
        chk("reset no_target",  int'(no_target),  0);
        chk("reset shot_count", int'(shot_count), 0);

        // Full formation, always-ready munition: round robin over the bottom row.
        reset = 1'b0; enable = 1'b1; alive = 6'b111111; fire_ready = 1'b1;
        shot_cycle(1, 0, 1);
        shot_cycle(1, 1, 2);
        shot_cycle(1, 2, 3);
        shot_cycle(1, 0, 4);

        // Lone survivor in row 0 column 1.
        alive = 6'b000010;
        shot_cycle(0, 1, 5);

        // Empty formation: three search cycles, then no_target, never a request.
        alive = 6'b000000;
        give_ticks(CDT);
        saw_valid = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (fire_valid) saw_valid = 1;
            if (i == 3) chk("no_target low during search", int'(no_target), 0);
        end
        chk("no_target after empty search", int'(no_target), 1);
        chk("no request on empty search", saw_valid, 0);

        // Shooter killed while waiting: request withdrawn and re-searched.
        alive = 6'b111111; fire_ready = 1'b0;
        give_ticks(CDT);
        wait_valid("request after empty search", 20);
        chk("held row", int'(fire_row), 1);
        chk("held col", int'(fire_col), 2);
        chk("no_target cleared by hit", int'(no_target), 0);
        alive = 6'b011011;
        @(negedge clk);
        chk("valid drops when shooter dies", int'(fire_valid), 0);
        wait_valid("re-request after kill", 20);
        chk("re-request row", int'(fire_row), 1);
        chk("re-request col", int'(fire_col), 0);
        chk("count unchanged by kill", int'(shot_count), 5);

        // Enable dropped mid-request.
        enable = 1'b0;
        @(negedge clk);
        chk("valid low after enable drop", int'(fire_valid), 0);
        chk("count kept over disable", int'(shot_count), 5);
        enable = 1'b1; fire_ready = 1'b1;
        give_ticks(CDT);
        wait_valid("request after re-enable", 20);
        chk("re-enable col keeps ptr", int'(fire_col), 0);
        @(negedge clk);
        chk("count after re-enable shot", int'(shot_count), 6);

        // Reset while the shot is in flight.
        reset = 1'b1;
        @(negedge clk);
        chk("mid-flight reset fire_valid", int'(fire_valid), 0);
        chk("mid-flight reset fire_row",   int'(fire_row),   0);
        chk("mid-flight reset fire_col",   int'(fire_col),   0);
        chk("mid-flight reset no_target",  int'(no_target),  0);
        chk("mid-flight reset shot_count", int'(shot_count), 0);

        // shot_busy never rises: cooldown starts four cycles after handshake.
        // With tick held high, the next request appears eight cycles later.
        reset = 1'b0;
        give_ticks(CDT);
        wait_valid("request after reset", 20);
        chk("post-reset col", int'(fire_col), 0);
        tick = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 7) chk("no request before timeout cooldown", int'(fire_valid), 0);
            if (i == 8) begin
                chk("request after timeout cooldown", int'(fire_valid), 1);
                chk("timeout next col", int'(fire_col), 1);
            end
        end
        tick = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
